// File: rtl/bsg_cgol_pkg.sv
// Shared definitions for the Game-of-Life job scheduler.
// Holds the controller state encoding and the id-width helper.
package bsg_cgol_pkg;

    typedef enum logic [1:0] {
        eIDLE = 2'd0,
        eLOAD = 2'd1,
        eRUN  = 2'd2,
        eDONE = 2'd3
    } cgol_sched_state_e;

    // A single requester still needs a one-bit id field.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_cgol_rr_arb.sv
// Round-robin arbiter: first valid requester at or after ptr_i wins.
// Returns a one-hot grant, its encoded index and an any-valid flag.
module bsg_cgol_rr_arb
    import bsg_cgol_pkg::*;
#(
    parameter  int num_req_p   = 2,
    localparam int id_width_lp = safe_clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]   v_i,
    input  logic [id_width_lp-1:0] ptr_i,
    output logic [num_req_p-1:0]   grant_o,
    output logic [id_width_lp-1:0] id_o,
    output logic                   v_o
);

    localparam logic [num_req_p-1:0] one_lp = num_req_p'(1'b1);

    // Scan from the farthest offset down so the closest requester to ptr_i wins last.
    always_comb begin
        grant_o = '0;
        id_o    = '0;
        v_o     = 1'b0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            int                   idx;
            logic [num_req_p-1:0] v_sh;
            idx  = int'(ptr_i) + i;
            idx  = (idx >= num_req_p) ? (idx - num_req_p) : idx;
            v_sh = v_i >> idx;
            if (v_sh[0]) begin
                grant_o = one_lp << idx;
                id_o    = id_width_lp'(idx);
                v_o     = 1'b1;
            end else begin
                v_o     = v_o;
            end
        end
    end

endmodule

// File: rtl/bsg_cgol_sched.sv
// Job scheduler sharing one Game-of-Life cell array among several requesters:
// grants a job, loads its board, steps the array N generations, returns the result.
module bsg_cgol_sched
    import bsg_cgol_pkg::*;
#(
    parameter  int board_width_p     = 64,
    parameter  int max_game_length_p = 1024,
    parameter  int num_req_p         = 2,
    localparam int frames_width_lp   = $clog2(max_game_length_p + 1),
    localparam int id_width_lp       = safe_clog2(num_req_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [num_req_p-1:0]                 req_v_i,
    input  logic [num_req_p*board_width_p-1:0]   req_board_i,
    input  logic [num_req_p*frames_width_lp-1:0] req_frames_i,
    output logic [num_req_p-1:0]                 req_ready_o,
    output logic                                 cell_update_o,
    output logic [board_width_p-1:0]             cell_board_o,
    output logic                                 cell_en_o,
    input  logic [board_width_p-1:0]             cell_board_i,
    output logic                                 v_o,
    output logic [board_width_p-1:0]             board_o,
    output logic [id_width_lp-1:0]               id_o,
    input  logic                                 yumi_i
);

    localparam logic [frames_width_lp-1:0] max_frames_lp = frames_width_lp'(max_game_length_p);
    localparam logic [frames_width_lp-1:0] one_frame_lp  = frames_width_lp'(1);

    cgol_sched_state_e            state_q, state_d;
    logic [id_width_lp-1:0]       rr_q, rr_d;
    logic [frames_width_lp-1:0]   cnt_q, cnt_d;
    logic [id_width_lp-1:0]       id_q, id_d;
    logic [board_width_p-1:0]     board_q;
    logic [frames_width_lp-1:0]   frames_q;
    logic                         cell_update_q, cell_en_q, v_q;

    logic [num_req_p-1:0]         grant_s;
    logic [id_width_lp-1:0]       grant_id_s;
    logic                         grant_v_s;
    logic                         handshake_s;
    logic [id_width_lp-1:0]       rr_next_s;
    logic [board_width_p-1:0]     sel_board_s;
    logic [frames_width_lp-1:0]   sel_frames_s;
    logic [frames_width_lp-1:0]   clamp_frames_s;
    logic                         last_s;

    bsg_cgol_rr_arb #(
        .num_req_p (num_req_p)
    ) arb (
        .v_i     (req_v_i),
        .ptr_i   (rr_q),
        .grant_o (grant_s),
        .id_o    (grant_id_s),
        .v_o     (grant_v_s)
    );

    assign req_ready_o   = (state_q == eIDLE) ? grant_s : '0;
    assign handshake_s   = (state_q == eIDLE) & grant_v_s;
    assign rr_next_s     = (int'(grant_id_s) == num_req_p - 1) ? '0
                                                                : grant_id_s + id_width_lp'(1);
    assign last_s        = (cnt_q == frames_q - one_frame_lp);

    assign cell_update_o = cell_update_q;
    assign cell_en_o     = cell_en_q;
    assign cell_board_o  = board_q;
    assign v_o           = v_q;
    assign board_o       = cell_board_i;
    assign id_o          = id_q;

    // Mux out the granted requester's board and frame count (grant is one-hot).
    always_comb begin
        sel_board_s  = '0;
        sel_frames_s = '0;
        for (int i = 0; i < num_req_p; i++) begin
            sel_board_s  = sel_board_s
                         | (req_board_i[i*board_width_p +: board_width_p] & {board_width_p{grant_s[i]}});
            sel_frames_s = sel_frames_s
                         | (req_frames_i[i*frames_width_lp +: frames_width_lp] & {frames_width_lp{grant_s[i]}});
        end
        clamp_frames_s = (sel_frames_s > max_frames_lp) ? max_frames_lp : sel_frames_s;
    end

    // Next-state logic for the job controller.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        case (state_q)
            eIDLE: begin
                if (grant_v_s) begin
                    state_d = eLOAD;
                    rr_d    = rr_next_s;
                    id_d    = grant_id_s;
                end else begin
                    state_d = eIDLE;
                end
            end
            eLOAD: begin
                cnt_d   = '0;
                state_d = (frames_q == '0) ? eDONE : eRUN;
            end
            eRUN: begin
                cnt_d   = cnt_q + one_frame_lp;
                state_d = last_s ? eDONE : eRUN;
            end
            eDONE: begin
                state_d = yumi_i ? eIDLE : eDONE;
            end
            default: begin
                state_d = eIDLE;
            end
        endcase
    end

    // Controller state and registered outputs; a reset aborts any job in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= eIDLE;
            rr_q          <= '0;
            cnt_q         <= '0;
            id_q          <= '0;
            cell_update_q <= 1'b0;
            cell_en_q     <= 1'b0;
            v_q           <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            id_q          <= id_d;
            cell_update_q <= (state_d == eLOAD);
            cell_en_q     <= (state_d == eRUN);
            v_q           <= (state_d == eDONE);
        end
    end

    // Job payload is only meaningful once a handshake has latched it.
    always_ff @(posedge clk_i) begin
        if (handshake_s && !reset_i) begin
            board_q  <= sel_board_s;
            frames_q <= clamp_frames_s;
        end else begin
            board_q  <= board_q;
            frames_q <= frames_q;
        end
    end

endmodule

// File: doc/bsg_cgol_sched.md
BSG_CGOL_SCHED -- requirements
Module: bsg_cgol_sched

Interface
REQ-001 The block SHALL have parameter board_width_p, default 64: number of cells in the flattened board.
REQ-002 The block SHALL have parameter max_game_length_p, default 1024: maximum frames per job.
REQ-003 The block SHALL have parameter num_req_p, default 2: number of requesters sharing one cell array.
REQ-004 The block SHALL define derived localparam frames_width_lp = clog2(max_game_length_p+1).
REQ-005 The block SHALL define derived localparam id_width_lp = safe clog2(num_req_p).
REQ-006 The block SHALL have the following ports, clock and reset first:
  - clk_i  in  1  sole clock; all state on its rising edge.
  - reset_i  in  1  reset; synchronous, active-high.
  - req_v_i  in  num_req_p  per-requester job valid.
  - req_board_i  in  num_req_p*board_width_p  per-requester initial board.
  - req_frames_i  in  num_req_p*frames_width_lp  per-requester frame count.
  - req_ready_o  out  num_req_p  per-requester accept; at most one bit high.
  - cell_update_o  out  1  load cell_board_o into the cell array this cycle.
  - cell_board_o  out  board_width_p  board to load.
  - cell_en_o  out  1  advance cell array one generation this cycle.
  - cell_board_i  in  board_width_p  current cell array state.
  - v_o  out  1  result valid.
  - board_o  out  board_width_p  final board.
  - id_o  out  id_width_lp  index of the requester owning the result.
  - yumi_i  in  1  consumer takes result; legal only when v_o=1.

Function
REQ-007 The block SHALL implement a 4-state FSM: eIDLE, eLOAD, eRUN, eDONE.
REQ-008 eIDLE: grant = first requester with req_v_i set, scanning round-robin from priority pointer rr_r.
  - req_ready_o SHALL be one-hot at grant when any req_v_i is set, else zero; it SHALL depend only on req_v_i and rr_r.
REQ-009 On handshake (req_v_i[g] & req_ready_o[g]):
  - latch board, frames and id=g;
  - set rr_r to (g+1) mod num_req_p;
  - go to eLOAD.
REQ-010 A latched frames value greater than max_game_length_p SHALL be clamped to max_game_length_p.
REQ-011 eLOAD: exactly one cycle.
  - cell_update_o=1, cell_board_o=latched board.
  - Counter clears to 0.
  - Next state eDONE if frames==0, else eRUN.
REQ-012 eRUN: cell_en_o=1 every cycle; counter increments each cycle.
  - Leave to eDONE in the cycle the counter reaches frames-1, so cell_en_o is high exactly frames cycles.
REQ-013 eDONE: v_o=1, board_o=cell_board_i, id_o=latched id.
  - cell_en_o=0 and cell_update_o=0.
  - On yumi_i go to eIDLE; otherwise hold, with outputs stable.
REQ-014 req_ready_o SHALL be zero in every state other than eIDLE; requests arriving mid-job wait and are not dropped.
REQ-015 Latency: handshake at cycle T gives v_o at T+2+frames.
REQ-016 Requester valids changing while not granted SHALL NOT disturb a job in progress.
REQ-017 cell_board_o SHALL hold the latched board outside eLOAD; cell_update_o qualifies it.
REQ-018 The counter SHALL be frames_width_lp bits and SHALL never wrap within a job.

Reset
REQ-019 Reset SHALL be synchronous and active-high.
REQ-020 While reset_i is high, or in the cycle after it falls, the outputs SHALL be:
  - state eIDLE, rr_r=0, counter=0;
  - v_o=0, cell_en_o=0, cell_update_o=0, id_o=0;
  - req_ready_o driven only by req_v_i with rr_r=0.
REQ-021 Reset asserted in any state SHALL abort the job without emitting a result; latched board and frames need no reset.

Structure
REQ-022 The state enum SHALL live in shared package bsg_cgol_pkg, next to the controller's states.
REQ-023 The round-robin grant SHALL be one sub-module, bsg_cgol_rr_arb, taking valids and a pointer and returning a one-hot grant plus an encoded id.
REQ-024 The top level SHALL hold the FSM, counter and job registers; target 150-300 RTL lines.

Verification
REQ-025 Single job: req_v_i=01, frames=3 -> cell_update_o one cycle, cell_en_o exactly 3 cycles, v_o at T+5, id_o=0, board_o matches golden model.
REQ-026 Zero frames: frames=0 -> no cell_en_o, v_o at T+2, board_o equals the input board.
REQ-027 Contention: both valid continuously, 4 jobs -> grants alternate 0,1,0,1; no req_ready_o outside eIDLE.
REQ-028 Backpressure: yumi_i held low 10 cycles in eDONE -> v_o, board_o and id_o stable; new requests not accepted until yumi.
REQ-029 Max and clamp: frames=max_game_length_p gives exactly max cell_en_o pulses; frames=max+1 gives the same result.
REQ-030 Reset mid-eRUN (counter=2 of 5) -> next cycle eIDLE, v_o=0, cell_en_o=0, rr_r=0; a following job runs normally.
